// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the logic-op arbiter: opcodes, FSM states and the
// opcode-to-datapath-control decoder.
package logic_op_arbiter_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_NOT_A  = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic c_and;
    logic c_or;
    logic c_xor;
    logic c_inv;
    logic zero_b;
  } ctl_t;

  // NOT_A and PASS_A reuse the XOR path with B forced to zero.
  function automatic ctl_t decode_op(input logic [2:0] op);
    ctl_t c;
    case (op)
      OP_AND:   c = '{c_and: 1'b1, c_or: 1'b0, c_xor: 1'b0, c_inv: 1'b0, zero_b: 1'b0};
      OP_OR:    c = '{c_and: 1'b0, c_or: 1'b1, c_xor: 1'b0, c_inv: 1'b0, zero_b: 1'b0};
      OP_XOR:   c = '{c_and: 1'b0, c_or: 1'b0, c_xor: 1'b1, c_inv: 1'b0, zero_b: 1'b0};
      OP_NAND:  c = '{c_and: 1'b1, c_or: 1'b0, c_xor: 1'b0, c_inv: 1'b1, zero_b: 1'b0};
      OP_NOR:   c = '{c_and: 1'b0, c_or: 1'b1, c_xor: 1'b0, c_inv: 1'b1, zero_b: 1'b0};
      OP_XNOR:  c = '{c_and: 1'b0, c_or: 1'b0, c_xor: 1'b1, c_inv: 1'b1, zero_b: 1'b0};
      OP_NOT_A: c = '{c_and: 1'b0, c_or: 1'b0, c_xor: 1'b1, c_inv: 1'b1, zero_b: 1'b1};
      default:  c = '{c_and: 1'b0, c_or: 1'b0, c_xor: 1'b1, c_inv: 1'b0, zero_b: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between the issue logic (master) and the
// logic-op arbiter (slave).
interface logic_op_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_zero;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/logic_op_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap and returns the
// first requester found as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);
  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/unit_logic.sv
// Bitwise logic datapath: OR of the selected and/or/xor terms, optionally inverted.
module unit_logic #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_and,
  input  logic             c_or,
  input  logic             c_xor,
  input  logic             c_inv,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] r;

  always_comb begin
    r = '0;
    if (c_and) r = r | (a & b);
    if (c_or)  r = r | (a | b);
    if (c_xor) r = r | (a ^ b);
    y = r ^ {WIDTH{c_inv}};
  end
endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one unit_logic between NREQ requesters: round-robin accept, one-cycle
// execute, registered response held until the consumer takes it.
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst_n,
  logic_op_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, grant_id, id_p0, rsp_id_q;
  logic [NREQ-1:0]  grant;
  logic             grant_en, accept, rsp_hs;
  ctl_t             ctl_dec;
  logic [3:0]       sel_p0;
  logic [WIDTH-1:0] a_p0, b_p0, req_a_sel, req_b_sel;
  logic [WIDTH-1:0] u_a, u_b, u_y, rsp_data_q;
  logic             u_and, u_or, u_xor, u_inv, rsp_zero_q;

  assign rsp_hs = (state == ST_RESP) && bus.rsp_ready;
  // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
  assign grant_en = rst_n && ((state == ST_IDLE) || rsp_hs);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (bus.req_valid),
    .en       (grant_en),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign accept    = |grant;
  assign ctl_dec   = decode_op(bus.req_op[int'(grant_id)*3 +: 3]);
  assign req_a_sel = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign req_b_sel = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = accept ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operation latched at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p0 <= {ctl_dec.c_and, ctl_dec.c_or, ctl_dec.c_xor, ctl_dec.c_inv};
      a_p0   <= req_a_sel;
      b_p0   <= ctl_dec.zero_b ? '0 : req_b_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= IDW'(NREQ - 1);
      id_p0      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        ptr   <= grant_id;
        id_p0 <= grant_id;
      end
      // Stage p1: result captured; held until the response handshake.
      if (state == ST_EXEC) begin
        rsp_data_q <= u_y;
        rsp_zero_q <= (u_y == '0);
        rsp_id_q   <= id_p0;
      end
    end
  end

  always_comb begin
    u_a   = '0;
    u_b   = '0;
    u_and = 1'b0;
    u_or  = 1'b0;
    u_xor = 1'b0;
    u_inv = 1'b0;
    if (state != ST_IDLE) begin
      u_a = a_p0;
      u_b = b_p0;
      {u_and, u_or, u_xor, u_inv} = sel_p0;
    end
  end

  unit_logic #(.WIDTH(WIDTH)) u_logic (
    .a     (u_a),
    .b     (u_b),
    .c_and (u_and),
    .c_or  (u_or),
    .c_xor (u_xor),
    .c_inv (u_inv),
    .y     (u_y)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.busy      = (state != ST_IDLE);
endmodule
